// File: rtl/rxelencheck_pkg.sv
// Shared Ethernet framing constants for the RX path, expressed in bytes and in
// MII nibbles, plus the width of the statistics counters.
package rxelencheck_pkg;

  localparam int ETH_MINBYTES   = 64;
  localparam int ETH_MAXBYTES   = 1518;
  localparam int ETH_MINNIBBLES = 2 * ETH_MINBYTES;
  localparam int ETH_MAXNIBBLES = 2 * ETH_MAXBYTES;
  localparam int STAT_W         = 16;

endpackage

// File: rtl/satcount16.sv
// 16-bit saturating event counter with synchronous clear (clear beats increment)
// and asynchronous active-low reset.
module satcount16
  import rxelencheck_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + STAT_W'(1);
    end
  end

endmodule

// File: rtl/rxelencheck.sv
// RX frame length policer: forwards beats with one i_ce of latency, truncates
// giants at the first excess beat, flags runts at end of frame, keeps statistics.
module rxelencheck
  import rxelencheck_pkg::*;
#(
  parameter int DW       = 4,
  parameter int MINBEATS = ETH_MINNIBBLES,
  parameter int MAXBEATS = ETH_MAXNIBBLES
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_ce,
  input  logic              i_min_en,
  input  logic              i_max_en,
  input  logic              i_cancel,
  input  logic              i_v,
  input  logic [DW-1:0]     i_d,
  input  logic              i_clr_stats,
  output logic              o_v,
  output logic [DW-1:0]     o_d,
  output logic              o_err,
  output logic              o_done,
  output logic              o_runt,
  output logic              o_giant,
  output logic [STAT_W-1:0] o_nrunts,
  output logic [STAT_W-1:0] o_ngiants,
  output logic [STAT_W-1:0] o_nframes
);

  localparam int LGCNT = $clog2(MAXBEATS + 2);
  localparam logic [LGCNT-1:0] CNT_ONE = LGCNT'(1);
  localparam logic [LGCNT-1:0] CNT_MIN = LGCNT'(MINBEATS);
  localparam logic [LGCNT-1:0] CNT_MAX = LGCNT'(MAXBEATS);
  localparam logic [LGCNT-1:0] CNT_SAT = LGCNT'(MAXBEATS + 1);

  typedef enum logic [1:0] {IDLE, COUNT, GIANT, DROP} state_t;

  state_t          state, state_n;
  logic [LGCNT-1:0] count, count_n;
  logic            armed, armed_n;
  logic            v_n, err_n, done_n, runt_n, giant_n;
  logic [DW-1:0]   d_n;

  // armed stays low after reset until a low i_v beat is seen, so a frame that
  // straddles reset release is dropped rather than counted as a short frame.
  always_comb begin
    // NOTE: every value written here is defaulted first so no latch is inferred.
    state_n = state;
    count_n = count;
    armed_n = armed | ~i_v;
    v_n     = 1'b0;
    d_n     = o_d;
    err_n   = o_err;
    done_n  = 1'b0;
    runt_n  = 1'b0;
    giant_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_v) begin
          if (i_cancel || !armed) begin
            state_n = DROP;
          end else begin
            state_n = COUNT;
            count_n = CNT_ONE;
            v_n     = 1'b1;
            d_n     = i_d;
          end
        end
      end
      COUNT: begin
        if (i_cancel) begin
          state_n = DROP;
          count_n = '0;
        end else if (i_v) begin
          if ((count == CNT_MAX) && i_max_en) begin
            state_n = GIANT;
            count_n = CNT_SAT;
            err_n   = 1'b1;
          end else begin
            if (count != CNT_SAT) count_n = count + CNT_ONE;
            v_n = 1'b1;
            d_n = i_d;
          end
        end else begin
          state_n = IDLE;
          count_n = '0;
          done_n  = 1'b1;
          runt_n  = i_min_en && (count < CNT_MIN);
        end
      end
      GIANT: begin
        if (i_cancel) begin
          state_n = DROP;
          count_n = '0;
          err_n   = 1'b0;
        end else if (!i_v) begin
          state_n = IDLE;
          count_n = '0;
          err_n   = 1'b0;
          done_n  = 1'b1;
          giant_n = 1'b1;
        end
      end
      DROP: begin
        count_n = '0;
        err_n   = 1'b0;
        if (!i_v && !i_cancel) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      count   <= '0;
      armed   <= 1'b0;
      o_v     <= 1'b0;
      o_d     <= '0;
      o_err   <= 1'b0;
      o_done  <= 1'b0;
      o_runt  <= 1'b0;
      o_giant <= 1'b0;
    end else if (i_ce) begin
      state   <= state_n;
      count   <= count_n;
      armed   <= armed_n;
      o_v     <= v_n;
      o_d     <= d_n;
      o_err   <= err_n;
      o_done  <= done_n;
      o_runt  <= runt_n;
      o_giant <= giant_n;
    end
  end

  // Statistics move on the same edge that raises o_done.
  logic inc_runt, inc_giant, inc_frame;
  assign inc_runt  = i_ce && done_n && runt_n;
  assign inc_giant = i_ce && done_n && giant_n;
  assign inc_frame = i_ce && done_n && !runt_n && !giant_n;

  satcount16 u_nrunts (
    .clk(i_clk), .rst_n(i_reset_n), .clr(i_clr_stats), .inc(inc_runt), .count(o_nrunts)
  );
  satcount16 u_ngiants (
    .clk(i_clk), .rst_n(i_reset_n), .clr(i_clr_stats), .inc(inc_giant), .count(o_ngiants)
  );
  satcount16 u_nframes (
    .clk(i_clk), .rst_n(i_reset_n), .clr(i_clr_stats), .inc(inc_frame), .count(o_nframes)
  );

endmodule

// File: tb/tb_rxelencheck.sv
// Scoreboard bench for rxelencheck: every i_ce beat driven pushes the expected
// registered outputs; a monitor pops and compares after each strobed edge.
module tb_rxelencheck;

  localparam int DW   = 4;
  localparam int MINB = 128;
  localparam int MAXB = 3036;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          err;
    logic          done;
    logic          runt;
    logic          giant;
    logic [15:0]   nr, ng, nf;
  } exp_t;

  logic          clk = 1'b0;
  logic          i_reset_n, i_ce, i_min_en, i_max_en, i_cancel, i_v, i_clr_stats;
  logic [DW-1:0] i_d;
  logic          o_v, o_err, o_done, o_runt, o_giant;
  logic [DW-1:0] o_d;
  logic [15:0]   o_nrunts, o_ngiants, o_nframes;

  logic          s_clr, s_inc;
  logic [15:0]   s_count;

  int   errors = 0;
  int   checks = 0;
  int   fwd_cnt = 0;
  int   m_nr = 0, m_ng = 0, m_nf = 0;
  exp_t sb[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  rxelencheck #(.DW(DW), .MINBEATS(MINB), .MAXBEATS(MAXB)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_min_en(i_min_en),
    .i_max_en(i_max_en), .i_cancel(i_cancel), .i_v(i_v), .i_d(i_d),
    .i_clr_stats(i_clr_stats), .o_v(o_v), .o_d(o_d), .o_err(o_err),
    .o_done(o_done), .o_runt(o_runt), .o_giant(o_giant),
    .o_nrunts(o_nrunts), .o_ngiants(o_ngiants), .o_nframes(o_nframes)
  );

  satcount16 u_sat (.clk(clk), .rst_n(i_reset_n), .clr(s_clr), .inc(s_inc), .count(s_count));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.v = 1'b0; e.d = '0; e.err = 1'b0; e.done = 1'b0; e.runt = 1'b0; e.giant = 1'b0;
    e.nr = 16'(m_nr); e.ng = 16'(m_ng); e.nf = 16'(m_nf);
    return e;
  endfunction

  task automatic beat(logic v, logic [DW-1:0] d, logic cancel, logic clr, logic ce, exp_t e);
    @(posedge clk); #1;
    i_v = v; i_d = d; i_cancel = cancel; i_clr_stats = clr; i_ce = ce;
    if (ce) sb.push_back(e);
  endtask

  // Strobe-low cycles carry junk so any leak past the i_ce gate shows up.
  task automatic gaps(int n);
    for (int g = 0; g < n; g++)
      beat(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, idle_exp());
  endtask

  task automatic idle(int n);
    for (int g = 0; g < n; g++) beat(1'b0, DW'($urandom), 1'b0, 1'b0, 1'b1, idle_exp());
  endtask

  task automatic send_frame(int len, int cancel_at, int gap, logic min_en, logic max_en, logic clr);
    exp_t          e;
    logic [DW-1:0] d;
    bit            cancelled, giant, runt;
    i_min_en  = min_en;
    i_max_en  = max_en;
    cancelled = 0;
    for (int k = 1; k <= len; k++) begin
      gaps(gap);
      if (cancel_at == k) cancelled = 1;
      d     = DW'($urandom);
      e     = idle_exp();
      e.v   = !cancelled && !(max_en && k > MAXB);
      e.d   = e.v ? d : '0;
      e.err = !cancelled && max_en && k > MAXB;
      beat(1'b1, d, 1'(cancel_at == k), 1'b0, 1'b1, e);
    end
    gaps(gap);
    if (cancel_at == len + 1) cancelled = 1;
    giant = max_en && len > MAXB;
    runt  = !giant && min_en && len < MINB;
    if (!cancelled) begin
      if (giant) m_ng++;
      else if (runt) m_nr++;
      else m_nf++;
    end
    if (clr) begin m_nr = 0; m_ng = 0; m_nf = 0; end
    e       = idle_exp();
    e.done  = !cancelled;
    e.runt  = !cancelled && runt;
    e.giant = !cancelled && giant;
    beat(1'b0, DW'($urandom), 1'(cancel_at == len + 1), clr, 1'b1, e);
    gaps(gap);
    idle(1);
  endtask

  // Monitor: strobed edges pop the scoreboard, other cycles must hold.
  initial begin
    exp_t e;
    bit   fired;
    last_exp = '{default: '0};
    forever begin
      @(posedge clk);
      fired = i_ce && i_reset_n;
      @(negedge clk);
      if (i_reset_n !== 1'b1) continue;
      if (fired) begin
        check("exp_pending", 32'(sb.size() != 0), 1);
        if (sb.size() == 0) continue;
        e = sb.pop_front();
        if (o_v) fwd_cnt++;
        last_exp = e;
      end else begin
        e = last_exp;
      end
      check(fired ? "o_v" : "hold_o_v", o_v, e.v);
      if (e.v) check(fired ? "o_d" : "hold_o_d", o_d, e.d);
      check(fired ? "o_err" : "hold_o_err", o_err, e.err);
      check(fired ? "o_done" : "hold_o_done", o_done, e.done);
      if (e.done) begin
        check("o_runt", o_runt, e.runt);
        check("o_giant", o_giant, e.giant);
      end
      check("o_nrunts", o_nrunts, e.nr);
      check("o_ngiants", o_ngiants, e.ng);
      check("o_nframes", o_nframes, e.nf);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    int fwd_start;
    i_reset_n = 1'b0; i_ce = 1'b0; i_min_en = 1'b1; i_max_en = 1'b1; i_cancel = 1'b0;
    i_v = 1'b0; i_d = '0; i_clr_stats = 1'b0; s_clr = 1'b0; s_inc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_v", o_v, 0);
    check("rst_o_d", o_d, 0);
    check("rst_o_err", o_err, 0);
    check("rst_o_done", {o_done, o_runt, o_giant}, 0);
    check("rst_counts", {o_nrunts, o_ngiants, o_nframes}, 0);
    i_reset_n = 1'b1;
    idle(2);

    send_frame(128, 0, 0, 1'b1, 1'b1, 1'b0);
    send_frame(127, 0, 0, 1'b1, 1'b1, 1'b0);
    send_frame(127, 0, 0, 1'b0, 1'b1, 1'b0);
    send_frame(1, 0, 0, 1'b1, 1'b1, 1'b0);
    send_frame(MAXB, 0, 0, 1'b1, 1'b1, 1'b0);

    fwd_start = fwd_cnt;
    send_frame(3040, 0, 0, 1'b1, 1'b1, 1'b0);
    check("giant_fwd_beats", fwd_cnt - fwd_start, MAXB);

    send_frame(200, 50, 0, 1'b1, 1'b1, 1'b0);
    send_frame(130, 0, 0, 1'b1, 1'b1, 1'b0);
    send_frame(130, 131, 0, 1'b1, 1'b1, 1'b0);
    send_frame(128, 0, 3, 1'b1, 1'b1, 1'b0);
    send_frame(127, 0, 0, 1'b1, 1'b1, 1'b1);
    send_frame(127, 0, 0, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a frame, released while i_v is still high.
    i_min_en = 1'b1; i_max_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      e     = idle_exp();
      e.v   = 1'b1;
      e.d   = DW'(k);
      beat(1'b1, DW'(k), 1'b0, 1'b0, 1'b1, e);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    i_reset_n = 1'b0;
    m_nr = 0; m_ng = 0; m_nf = 0;
    last_exp = idle_exp();
    #1;
    check("async_rst_o_v", o_v, 0);
    check("async_rst_o_d", o_d, 0);
    check("async_rst_counts", {o_nrunts, o_ngiants, o_nframes}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    sb.push_back(idle_exp());
    for (int k = 0; k < 5; k++) beat(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1, idle_exp());
    idle(2);
    send_frame(130, 0, 0, 1'b1, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    i_ce = 1'b0;

    // Saturation corner on the counter block itself.
    s_inc = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("sat_preload", s_count, 16'hffff);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold", s_count, 16'hffff);
    s_clr = 1'b1;
    @(posedge clk);
    #1;
    check("sat_clr_wins", s_count, 16'h0000);
    s_clr = 1'b0;
    @(posedge clk);
    #1;
    check("sat_restart", s_count, 16'h0001);
    s_inc = 1'b0;

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rxelencheck.md
# rxelencheck

Parametrised receive-frame length policer for the Ethernet RX path. It sits after preamble stripping and before CRC checking. It counts data beats per frame and forwards the stream with one `i_ce` of latency. Frames shorter than MINBEATS are flagged as runts at end of frame; frames longer than MAXBEATS are truncated and flagged as giants as soon as the excess beat arrives, so downstream can cancel early. Saturating runt, giant and good-frame counters feed the network-control register file.

## Interface
- DW, 4: data beat width in bits (4 = MII nibble, 8 = byte path).
- MINBEATS, 128: minimum legal frame length in beats, CRC included (64 bytes of nibbles).
- MAXBEATS, 3036: maximum legal frame length in beats, CRC included (1518 bytes of nibbles). Constraint: 2 ≤ MINBEATS < MAXBEATS.
- i_clk  in  1  system clock.
- i_reset_n  in  1  reset; one clock, asynchronous assert, active-low.
- i_ce  in  1  beat strobe; all frame logic advances only when high.
- i_min_en  in  1  enable runt detection.
- i_max_en  in  1  enable giant detection and truncation.
- i_cancel  in  1  upstream abort of the current frame.
- i_v  in  1  frame-valid; one frame is one contiguous run of i_v high on i_ce cycles.
- i_d  in  DW  data beat.
- i_clr_stats  in  1  synchronous clear of all statistics counters; ignores i_ce.
- o_v  out  1  forwarded valid.
- o_d  out  DW  forwarded data.
- o_err  out  1  level; frame is currently a giant.
- o_done  out  1  one-i_ce pulse at end of a non-cancelled frame.
- o_runt, o_giant  out  1 each  frame verdict; valid only while o_done is high.
- o_nrunts, o_ngiants, o_nframes  out  16 each  saturating counts of runts, giants and good frames.

## Operation
- Beat counter width: LGCNT = $clog2(MAXBEATS+2). The counter saturates at MAXBEATS+1.
- States: IDLE, COUNT, GIANT, DROP.
- IDLE, on i_ce && i_v && !i_cancel: go to COUNT, count = 1, forward the beat.
- COUNT, on i_ce && i_v: increment count.
  - If the incoming beat is beat MAXBEATS+1 and i_max_en is high: go to GIANT, set o_err, do not forward the beat.
- COUNT, on i_ce && !i_v: end of frame, go to IDLE.
  - Pulse o_done.
  - o_runt = i_min_en && (count < MINBEATS).
  - o_giant = 0.
- GIANT: o_v is held 0; remain until i_ce && !i_v, then pulse o_done with o_giant = 1 and o_runt = 0, clear o_err, go to IDLE.
- i_cancel with i_ce in COUNT or GIANT (or with i_v in IDLE): go to DROP.
  - o_v = 0 from that beat onward; o_err cleared.
  - No o_done and no statistics update.
  - DROP returns to IDLE on i_ce && !i_v && !i_cancel.
- Statistics, updated in the o_done cycle:
  - runt → o_nrunts +1.
  - giant → o_ngiants +1.
  - otherwise → o_nframes +1.
  - Each counter saturates at 16'hffff. If i_clr_stats is asserted in the same cycle, the clear wins.
- Enables are sampled at the point of decision (the excess beat, or end of frame); changing them mid-frame is legal.

## Timing
- Reset: state IDLE, count 0, every output 0.
- o_v and o_d are registered and update only on i_ce, so latency is exactly one i_ce beat. When i_ce is low, outputs hold.
- o_done, o_runt and o_giant are registered and assert on the first i_ce where i_v is low after a frame. They are high for exactly one i_ce beat and cleared on the next i_ce.
- o_err rises in the same register update that would have forwarded beat MAXBEATS+1, and falls with o_done.
- Boundary lengths:
  - count == MINBEATS is not a runt.
  - count == MAXBEATS is not a giant.
  - One-beat frame with i_min_en is a runt.
- i_cancel on the same i_ce that i_v falls: treated as a cancel, with no o_done.
- Reset asserted mid-frame: all state clears immediately. If i_v is still high when reset releases, the remainder of that frame goes to DROP; it is not counted.
- Consecutive frames need at least one i_ce with i_v low between them. That low beat is also the o_done beat.

## Structure
- Shared network package holds ETH_MINNIBBLES=128, ETH_MAXNIBBLES=3036 and their byte equivalents. State encoding stays local to the module.
- One sub-module, `satcount16`: 16-bit saturating incrementer with synchronous clear and asynchronous active-low reset. It is instantiated three times.

## Test plan
- 128-beat frame, both enables on → o_done with o_runt=0 and o_giant=0; o_nframes=1; output stream identical to input, delayed one i_ce.
- 127-beat frame → o_runt=1, o_nrunts=1. The same frame with i_min_en=0 → good frame, o_nframes +1.
- 3040-beat frame → o_v drops and o_err rises at beat 3037. o_done with o_giant=1 after i_v falls; o_ngiants=1; exactly 3036 beats forwarded.
- i_cancel at beat 50 of a 200-beat frame → o_v low from beat 50; no o_done; all counters unchanged. The next 130-beat frame passes as good.
- i_ce toggling 1-in-4 with a 128-beat frame → same verdict as with i_ce constant; outputs hold between strobes.
- Preload 65535 runts, then send one more runt with i_clr_stats asserted in the o_done cycle → o_nrunts=0. Separately, without a clear, o_nrunts stays at 65535.
